mem_dp_param: RTL and testbench

- Parametrised successor to the fixed 128x52 single-port table RAM used by the AWGN core's coefficient and sample stores.
- Simple dual-port: one write port, one read port, one clock.
- Adds an automatic clear-on-reset sweep, per-byte write enables, configurable read latency with a valid strobe, and selectable read-during-write semantics.

---
 rtl/mem_pkg.sv | 26 ++
 rtl/mem_dp_param_if.sv | 29 ++
 rtl/mem_dp_core.sv | 26 ++
 rtl/mem_dp_param.sv | 141 ++++++++++++++
 tb/tb_mem_dp_param.sv | 391 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// Shared types and helpers for the parametrised dual-port table RAM.
package mem_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam int MAX_DW = 128;
  localparam int MAX_NB = 16;

  function automatic int nb_of(input int dw);
    return (dw + 7) / 8;
  endfunction

  // Bits at or above dw stay 0, so a partial top lane only covers real data bits.
  function automatic logic [MAX_DW-1:0] lane_mask(input logic [MAX_NB-1:0] wbe, input int dw);
    logic [MAX_DW-1:0] m;
    m = '0;
    for (int k = 0; k < MAX_DW; k++) begin
      if (k < dw) m[k] = wbe[k/8];
    end
    return m;
  endfunction

endpackage

// File: rtl/mem_dp_param_if.sv
// Write/read port bundle of mem_dp_param; slave is the RAM, master the client.
interface mem_dp_param_if
  import mem_pkg::*;
#(
  parameter int DW = 52,
  parameter int AW = 7
) ();
  localparam int NB = nb_of(DW);

  logic          init_busy;
  logic          we;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;
  logic [NB-1:0] wbe;
  logic          re;
  logic [AW-1:0] raddr;
  logic [DW-1:0] rdata;
  logic          rvalid;

  modport master (
    input  init_busy, rdata, rvalid,
    output we, waddr, wdata, wbe, re, raddr
  );

  modport slave (
    output init_busy, rdata, rvalid,
    input  we, waddr, wdata, wbe, re, raddr
  );
endinterface

// File: rtl/mem_dp_core.sv
// Raw storage: bit-masked synchronous write, registered read returning pre-write data.
// No reset and no address checks; the wrapper keeps addresses in range.
module mem_dp_core #(
  parameter int DW    = 52,
  parameter int AW    = 7,
  parameter int DEPTH = 128
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [DW-1:0] wmask_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);
  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= (mem_q[waddr_i] & ~wmask_i) | (wdata_i & wmask_i);
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/mem_dp_param.sv
// Simple dual-port RAM with reset-time clear sweep, byte-lane writes and RD_LAT-cycle reads.
// No backpressure: both ports accept every cycle once the sweep has finished.
module mem_dp_param
  import mem_pkg::*;
#(
  parameter int            DW       = 52,
  parameter int            AW       = 7,
  parameter int            DEPTH    = 128,
  parameter int            RD_LAT   = 1,
  parameter int            RDW_NEW  = 0,
  parameter logic [DW-1:0] INIT_VAL = '0
) (
  input logic           clk,
  input logic           rst,
  mem_dp_param_if.slave bus
);
  localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);
  localparam logic [AW:0]   DEPTH_W = (AW + 1)'(DEPTH);

  state_t        state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic          run;

  logic [DW-1:0] wmask;
  logic          wr_ok, rd_ok, rd_in;
  logic          core_we;
  logic [AW-1:0] core_waddr;
  logic [DW-1:0] core_wdata, core_wmask, core_rdata;

  logic          v1_q, zero1_q, rdw1_q;
  logic [DW-1:0] mrg_mask_q, mrg_data_q;
  logic [DW-1:0] rd1_dat;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_INIT;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    if (state_q == ST_INIT) begin
      ptr_d = ptr_q + AW'(1);
      if (ptr_q == LAST) begin
        state_d = ST_RUN;
        ptr_d   = '0;
      end
    end
  end

  assign run           = (state_q == ST_RUN);
  assign bus.init_busy = !run;

  assign wmask = DW'(lane_mask(MAX_NB'(bus.wbe), DW));
  assign wr_ok = run && bus.we && ({1'b0, bus.waddr} < DEPTH_W);
  assign rd_ok = run && bus.re;
  assign rd_in = ({1'b0, bus.raddr} < DEPTH_W);

  // The sweep owns the write port until it finishes.
  always_comb begin
    core_we    = wr_ok;
    core_waddr = bus.waddr;
    core_wdata = bus.wdata;
    core_wmask = wmask;
    if (!run) begin
      core_we    = 1'b1;
      core_waddr = ptr_q;
      core_wdata = INIT_VAL;
      core_wmask = '1;
    end
  end

  mem_dp_core #(
    .DW    (DW),
    .AW    (AW),
    .DEPTH (DEPTH)
  ) u_core (
    .clk_i   (clk),
    .we_i    (core_we),
    .waddr_i (core_waddr),
    .wdata_i (core_wdata),
    .wmask_i (core_wmask),
    .re_i    (rd_ok && rd_in),
    .raddr_i (bus.raddr),
    .rdata_o (core_rdata)
  );

  // zero1_q forces rdata to 0 after reset and for out-of-range reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q    <= 1'b0;
      zero1_q <= 1'b1;
      rdw1_q  <= 1'b0;
    end else begin
      v1_q <= rd_ok;
      if (rd_ok) begin
        zero1_q <= !rd_in;
        rdw1_q  <= (RDW_NEW != 0) && wr_ok && (bus.waddr == bus.raddr);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rd_ok) begin
      mrg_mask_q <= wmask;
      mrg_data_q <= bus.wdata;
    end
  end

  always_comb begin
    rd1_dat = core_rdata;
    if (rdw1_q) rd1_dat = (core_rdata & ~mrg_mask_q) | (mrg_data_q & mrg_mask_q);
    if (zero1_q) rd1_dat = '0;
  end

  if (RD_LAT == 2) begin : g_lat2
    logic [DW-1:0] rdata_q;
    logic          v2_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        rdata_q <= '0;
        v2_q    <= 1'b0;
      end else begin
        v2_q <= v1_q;
        if (v1_q) rdata_q <= rd1_dat;
      end
    end

    assign bus.rdata  = rdata_q;
    assign bus.rvalid = v2_q;
  end else begin : g_lat1
    assign bus.rdata  = rd1_dat;
    assign bus.rvalid = v1_q;
  end
endmodule

// File: tb/tb_mem_dp_param.sv
// Drives two RAM configurations with identical traffic and checks both against an array/calendar model.
module tb_mem_dp_param;
  localparam logic [51:0] IV = 52'h0_0000_DEAD_BEEF;

  typedef struct {
    logic        rs;
    logic        w;
    logic [6:0]  wa;
    logic [51:0] wd;
    logic [6:0]  be;
    logic        r;
    logic [6:0]  ra;
  } op_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        we = 1'b0, re = 1'b0;
  logic [6:0]  waddr = '0, raddr = '0, wbe = '0;
  logic [51:0] wdata = '0;

  always #5 clk = ~clk;

  mem_dp_param_if #(.DW(52), .AW(7)) bus0 ();
  mem_dp_param_if #(.DW(52), .AW(7)) bus1 ();

  assign bus0.we = we;  assign bus0.waddr = waddr;  assign bus0.wdata = wdata;
  assign bus0.wbe = wbe; assign bus0.re = re;        assign bus0.raddr = raddr;
  assign bus1.we = we;  assign bus1.waddr = waddr;  assign bus1.wdata = wdata;
  assign bus1.wbe = wbe; assign bus1.re = re;        assign bus1.raddr = raddr;

  mem_dp_param #(.DW(52), .AW(7), .DEPTH(128), .RD_LAT(1), .RDW_NEW(0), .INIT_VAL(IV))
    u0 (.clk(clk), .rst(rst), .bus(bus0));
  mem_dp_param #(.DW(52), .AW(7), .DEPTH(96), .RD_LAT(2), .RDW_NEW(1), .INIT_VAL(IV))
    u1 (.clk(clk), .rst(rst), .bus(bus1));

  logic        o_v [2];
  logic        o_b [2];
  logic [51:0] o_d [2];
  assign o_v[0] = bus0.rvalid; assign o_b[0] = bus0.init_busy; assign o_d[0] = bus0.rdata;
  assign o_v[1] = bus1.rvalid; assign o_b[1] = bus1.init_busy; assign o_d[1] = bus1.rdata;

  // Reference model: word array, busy countdown and a delivery calendar keyed by edge number.
  logic [51:0] mm [2][128];
  int          cnt [2];
  bit          sv [2][4];
  logic [51:0] sd [2][4];
  logic        ev [2];
  logic        eb [2];
  logic [51:0] ed [2];
  int          ecnt = 0;
  int          nvec = 0;
  int          nerr = 0;
  logic [51:0] cap [2][4];
  int          nc [2];

  function automatic int dep(int i);  return (i == 0) ? 128 : 96; endfunction
  function automatic int lat(int i);  return (i == 0) ? 1 : 2;    endfunction
  function automatic bit rdwn(int i); return (i != 0);            endfunction

  function automatic logic [51:0] merge(logic [51:0] old, logic [51:0] nw, logic [6:0] be);
    logic [51:0] r;
    r = old;
    for (int b = 0; b < 52; b++) if (be[b/8]) r[b] = nw[b];
    return r;
  endfunction

  function automatic op_t mk(logic rs, logic w, logic [6:0] wa, logic [51:0] wd,
                             logic [6:0] be, logic r, logic [6:0] ra);
    op_t o;
    o.rs = rs; o.w = w; o.wa = wa; o.wd = wd; o.be = be; o.r = r; o.ra = ra;
    return o;
  endfunction
  function automatic op_t W(logic [6:0] a, logic [51:0] d, logic [6:0] be);
    return mk(1'b0, 1'b1, a, d, be, 1'b0, 7'h0);
  endfunction
  function automatic op_t R(logic [6:0] a);
    return mk(1'b0, 1'b0, 7'h0, 52'h0, 7'h0, 1'b1, a);
  endfunction
  function automatic op_t N();
    return mk(1'b0, 1'b0, 7'h0, 52'h0, 7'h0, 1'b0, 7'h0);
  endfunction
  function automatic op_t RS();
    return mk(1'b1, 1'b0, 7'h0, 52'h0, 7'h0, 1'b0, 7'h0);
  endfunction

  task automatic drive(op_t o);
    rst = o.rs; we = o.w; waddr = o.wa; wdata = o.wd; wbe = o.be; re = o.r; raddr = o.ra;
  endtask

  task automatic clr_cap();
    nc[0] = 0; nc[1] = 0;
  endtask

  task automatic tick();
    logic [51:0] r;
    @(posedge clk);
    ecnt++;
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        cnt[i] = dep(i);
        for (int s = 0; s < 4; s++) sv[i][s] = 1'b0;
        for (int a = 0; a < 128; a++) mm[i][a] = IV;
        ed[i] = '0;
      end else if (cnt[i] > 0) begin
        cnt[i]--;
      end else begin
        if (re) begin
          r = (int'(raddr) < dep(i)) ? mm[i][raddr] : 52'h0;
          if (rdwn(i) && we && waddr == raddr && int'(raddr) < dep(i)) r = merge(r, wdata, wbe);
          sv[i][(ecnt + lat(i) - 1) % 4] = 1'b1;
          sd[i][(ecnt + lat(i) - 1) % 4] = r;
        end
        if (we && int'(waddr) < dep(i)) mm[i][waddr] = merge(mm[i][waddr], wdata, wbe);
      end
      ev[i] = sv[i][ecnt % 4];
      if (ev[i]) begin
        ed[i] = sd[i][ecnt % 4];
        sv[i][ecnt % 4] = 1'b0;
      end
      eb[i] = (cnt[i] > 0);
    end
    #1;
    for (int i = 0; i < 2; i++) begin
      if (o_v[i] === 1'b1) begin
        if (nc[i] < 4) cap[i][nc[i]] = o_d[i];
        nc[i]++;
      end
    end
  endtask

  task automatic test_reset();
    op_t seq[$];
    int  hi [2];
    seq.push_back(RS()); seq.push_back(RS());
    for (int c = 0; c < 140; c++) seq.push_back((c == 50) ? W(7'h10, 52'h0, 7'h7F) :
                                                 (c == 60) ? R(7'h10) : N());
    seq.push_back(R(7'h00)); seq.push_back(R(7'h5A)); seq.push_back(R(7'h7F));
    seq.push_back(R(7'h10)); seq.push_back(N()); seq.push_back(N());
    hi[0] = 0; hi[1] = 0;
    clr_cap();
    foreach (seq[k]) begin
      drive(seq[k]);
      tick();
      for (int i = 0; i < 2; i++) begin
        if (k >= 1 && k <= 141 && o_b[i] === 1'b1) hi[i]++;
        nvec++;
        if (o_v[i] !== ev[i] || o_d[i] !== ed[i] || o_b[i] !== eb[i]) begin
          nerr++;
          $display("FAIL reset u%0d edge%0d: got v=%b d=%h busy=%b, want v=%b d=%h busy=%b",
                   i, ecnt, o_v[i], o_d[i], o_b[i], ev[i], ed[i], eb[i]);
        end
        if (k == 1) begin
          nvec++;
          if (o_v[i] !== 1'b0 || o_d[i] !== 52'h0 || o_b[i] !== 1'b1) begin
            nerr++;
            $display("FAIL reset_state u%0d: got v=%b d=%h busy=%b, want v=0 d=0 busy=1",
                     i, o_v[i], o_d[i], o_b[i]);
          end
        end
      end
    end
    for (int i = 0; i < 2; i++) begin
      nvec++;
      if (hi[i] != dep(i)) begin
        nerr++;
        $display("FAIL busy_len u%0d: got %0d cycles, want %0d", i, hi[i], dep(i));
      end
    end
    nvec++;
    if (nc[0] != 4 || cap[0][0] !== IV || cap[0][1] !== IV || cap[0][2] !== IV || cap[0][3] !== IV) begin
      nerr++;
      $display("FAIL init_val u0: got n=%0d %h %h %h %h, want 4 x %h",
               nc[0], cap[0][0], cap[0][1], cap[0][2], cap[0][3], IV);
    end
  endtask

  task automatic test_byte_enable();
    op_t seq[$];
    seq.push_back(W(7'h1F, 52'hF_FFFF_FFFF_FFFF, 7'h7F));
    seq.push_back(W(7'h1F, 52'h0, 7'b0000011));
    seq.push_back(R(7'h1F));
    seq.push_back(W(7'h1F, 52'h0, 7'b1000000));
    seq.push_back(R(7'h1F));
    seq.push_back(N()); seq.push_back(N()); seq.push_back(N());
    clr_cap();
    foreach (seq[k]) begin
      drive(seq[k]);
      tick();
      for (int i = 0; i < 2; i++) begin
        nvec++;
        if (o_v[i] !== ev[i] || o_d[i] !== ed[i] || o_b[i] !== eb[i]) begin
          nerr++;
          $display("FAIL byte_enable u%0d edge%0d: got v=%b d=%h busy=%b, want v=%b d=%h busy=%b",
                   i, ecnt, o_v[i], o_d[i], o_b[i], ev[i], ed[i], eb[i]);
        end
      end
    end
    for (int i = 0; i < 2; i++) begin
      nvec++;
      if (nc[i] != 2 || cap[i][0] !== 52'hF_FFFF_FFFF_0000 || cap[i][1] !== 52'h0_FFFF_FFFF_0000) begin
        nerr++;
        $display("FAIL byte_lanes u%0d: got n=%0d %h %h, want 2 reads F_FFFF_FFFF_0000 0_FFFF_FFFF_0000",
                 i, nc[i], cap[i][0], cap[i][1]);
      end
    end
  endtask

  task automatic test_streaming();
    op_t seq[$];
    int  e0;
    int  first [2];
    bit  gap [2];
    for (int a = 0; a < 4; a++) seq.push_back(W(7'(a), 52'(a + 1), 7'h7F));
    for (int a = 0; a < 4; a++) seq.push_back(R(7'(a)));
    for (int c = 0; c < 3; c++) seq.push_back(N());
    clr_cap();
    e0 = 0;
    first[0] = -1; first[1] = -1; gap[0] = 0; gap[1] = 0;
    foreach (seq[k]) begin
      if (k == 4) e0 = ecnt + 1;
      drive(seq[k]);
      tick();
      for (int i = 0; i < 2; i++) begin
        if (o_v[i] === 1'b1) begin
          if (first[i] < 0) first[i] = ecnt;
          else if (ecnt != first[i] + nc[i] - 1) gap[i] = 1;
        end
        nvec++;
        if (o_v[i] !== ev[i] || o_d[i] !== ed[i] || o_b[i] !== eb[i]) begin
          nerr++;
          $display("FAIL streaming u%0d edge%0d: got v=%b d=%h busy=%b, want v=%b d=%h busy=%b",
                   i, ecnt, o_v[i], o_d[i], o_b[i], ev[i], ed[i], eb[i]);
        end
      end
    end
    for (int i = 0; i < 2; i++) begin
      nvec++;
      if (nc[i] != 4 || gap[i] || first[i] != e0 + lat(i) - 1 || cap[i][0] !== 52'd1 ||
          cap[i][1] !== 52'd2 || cap[i][2] !== 52'd3 || cap[i][3] !== 52'd4) begin
        nerr++;
        $display("FAIL stream_lat u%0d: got n=%0d gap=%0d start=%0d data %0d %0d %0d %0d, want 4 contiguous from %0d data 1 2 3 4",
                 i, nc[i], gap[i], first[i], cap[i][0], cap[i][1], cap[i][2], cap[i][3], e0 + lat(i) - 1);
      end
    end
  endtask

  task automatic test_rdw();
    op_t seq[$];
    logic [51:0] want0;
    seq.push_back(W(7'h33, 52'h5A5A5A5A, 7'h7F));
    seq.push_back(mk(1'b0, 1'b1, 7'h33, 52'h01010101, 7'h7F, 1'b1, 7'h33));
    seq.push_back(R(7'h33));
    seq.push_back(N()); seq.push_back(N()); seq.push_back(N());
    clr_cap();
    foreach (seq[k]) begin
      drive(seq[k]);
      tick();
      for (int i = 0; i < 2; i++) begin
        nvec++;
        if (o_v[i] !== ev[i] || o_d[i] !== ed[i] || o_b[i] !== eb[i]) begin
          nerr++;
          $display("FAIL rdw u%0d edge%0d: got v=%b d=%h busy=%b, want v=%b d=%h busy=%b",
                   i, ecnt, o_v[i], o_d[i], o_b[i], ev[i], ed[i], eb[i]);
        end
      end
    end
    for (int i = 0; i < 2; i++) begin
      want0 = rdwn(i) ? 52'h01010101 : 52'h5A5A5A5A;
      nvec++;
      if (nc[i] != 2 || cap[i][0] !== want0 || cap[i][1] !== 52'h01010101) begin
        nerr++;
        $display("FAIL rdw_mode u%0d: got n=%0d %h %h, want 2 reads %h 01010101",
                 i, nc[i], cap[i][0], cap[i][1], want0);
      end
    end
  endtask

  task automatic test_out_of_range();
    op_t seq[$];
    seq.push_back(W(7'h60, 52'h123, 7'h7F));
    seq.push_back(R(7'h60));
    for (int a = 0; a < 96; a++) seq.push_back(R(7'(a)));
    seq.push_back(N()); seq.push_back(N());
    clr_cap();
    foreach (seq[k]) begin
      drive(seq[k]);
      tick();
      for (int i = 0; i < 2; i++) begin
        nvec++;
        if (o_v[i] !== ev[i] || o_d[i] !== ed[i] || o_b[i] !== eb[i]) begin
          nerr++;
          $display("FAIL out_of_range u%0d edge%0d: got v=%b d=%h busy=%b, want v=%b d=%h busy=%b",
                   i, ecnt, o_v[i], o_d[i], o_b[i], ev[i], ed[i], eb[i]);
        end
      end
    end
    for (int i = 0; i < 2; i++) begin
      nvec++;
      if (nc[i] != 97 || cap[i][0] !== ((i == 0) ? 52'h123 : 52'h0)) begin
        nerr++;
        $display("FAIL oob_read u%0d: got n=%0d first=%h, want 97 reads first=%h",
                 i, nc[i], cap[i][0], (i == 0) ? 52'h123 : 52'h0);
      end
    end
  endtask

  task automatic test_random();
    logic [6:0] wa, ra;
    clr_cap();
    for (int c = 0; c < 400; c++) begin
      wa = 7'($urandom);
      ra = ($urandom_range(0, 3) == 0) ? wa : 7'($urandom);
      drive(mk(1'b0, 1'($urandom), wa, {20'($urandom), 32'($urandom)}, 7'($urandom),
               1'($urandom), ra));
      tick();
      for (int i = 0; i < 2; i++) begin
        nvec++;
        if (o_v[i] !== ev[i] || o_d[i] !== ed[i] || o_b[i] !== eb[i]) begin
          nerr++;
          $display("FAIL random u%0d edge%0d: got v=%b d=%h busy=%b, want v=%b d=%h busy=%b",
                   i, ecnt, o_v[i], o_d[i], o_b[i], ev[i], ed[i], eb[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    op_t seq[$];
    int  hi [2];
    seq.push_back(RS());
    for (int c = 0; c < 40; c++) seq.push_back(N());
    seq.push_back(RS());
    for (int c = 0; c < 140; c++) seq.push_back(N());
    seq.push_back(R(7'h33));
    seq.push_back(RS());
    for (int c = 0; c < 3; c++) seq.push_back(N());
    hi[0] = 0; hi[1] = 0;
    clr_cap();
    foreach (seq[k]) begin
      drive(seq[k]);
      tick();
      for (int i = 0; i < 2; i++) begin
        if (k >= 41 && k <= 181 && o_b[i] === 1'b1) hi[i]++;
        nvec++;
        if (o_v[i] !== ev[i] || o_d[i] !== ed[i] || o_b[i] !== eb[i]) begin
          nerr++;
          $display("FAIL reset_mid u%0d edge%0d: got v=%b d=%h busy=%b, want v=%b d=%h busy=%b",
                   i, ecnt, o_v[i], o_d[i], o_b[i], ev[i], ed[i], eb[i]);
        end
        if (k == 183) begin
          nvec++;
          if (o_v[i] !== 1'b0 || o_d[i] !== 52'h0 || o_b[i] !== 1'b1) begin
            nerr++;
            $display("FAIL flush u%0d: got v=%b d=%h busy=%b, want v=0 d=0 busy=1",
                     i, o_v[i], o_d[i], o_b[i]);
          end
        end
      end
    end
    for (int i = 0; i < 2; i++) begin
      nvec++;
      if (hi[i] != dep(i)) begin
        nerr++;
        $display("FAIL restart_len u%0d: got %0d cycles, want %0d", i, hi[i], dep(i));
      end
    end
    nvec++;
    if (nc[1] != 0) begin
      nerr++;
      $display("FAIL inflight_drop u1: got %0d rvalid pulses, want 0", nc[1]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_byte_enable();
    test_streaming();
    test_rdw();
    test_out_of_range();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
